sw_debounce4: RTL and testbench
===============================

Name: sw_debounce4

Overview:
- Four-channel switch conditioner placed directly upstream of the lab combinational logic.
- Synchronises raw board switches sw_in[3:0] to clk and debounces them. Its outputs sw_out[3:0] drive the logic's sw0..sw3 inputs.
- Also produces one-cycle rise/fall strobes per channel, for later sequential labs that count edges.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per channel (minimum 2).
- DEBOUNCE_CYCLES, 50000, consecutive clk cycles a new level must persist before it is accepted (minimum 2; 1 ms at 50 MHz).
- CNT_WIDTH, 16, debounce counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sw_in  input  4  raw, asynchronous, bouncing switch levels.
- sw_out  output  4  debounced levels; bit i feeds sw<i> of the downstream logic.
- rise  output  4  one-cycle pulse when sw_out[i] goes 0->1.
- fall  output  4  one-cycle pulse when sw_out[i] goes 1->0.

Behaviour:
- Reset (rst_n=0, asynchronous, no wait for clk):
  - All synchroniser flops, counters, sw_out, rise and fall go to 0.
  - All channel FSMs go to IDLE_LO.
- Synchroniser: per-bit chain of SYNC_STAGES flops; sync[i] is the last stage. No logic between the stages.
- Channels are fully independent: four identical FSM/counter instances with no shared state.
- Per-channel FSM, states IDLE_LO, CHK_HI, IDLE_HI, CHK_LO:
  - IDLE_LO: sync=1 -> CHK_HI with cnt<=1. Otherwise stay, cnt<=0.
  - CHK_HI:
    - sync=0 -> IDLE_LO, cnt<=0 (bounce rejected).
    - else if cnt==DEBOUNCE_CYCLES-1 -> IDLE_HI, sw_out<=1, rise<=1, cnt<=0.
    - else cnt<=cnt+1.
  - IDLE_HI / CHK_LO: mirror of the above, with fall and sw_out<=0.
- rise and fall are registered:
  - asserted for exactly one cycle, in the same cycle sw_out changes;
  - otherwise 0;
  - never both high on one channel.
- Latency: if sw_in[i] changes before edge E0 and stays stable, sw_out[i] changes at edge E(SYNC_STAGES+DEBOUNCE_CYCLES-1).
  - Defaults: 50001 edges after E0.
  - Test config S=2, N=4: edge E5, i.e. the 6th edge.
- Rejection: any pulse or glitch whose synchronised width is shorter than DEBOUNCE_CYCLES cycles never changes sw_out or generates a strobe. The counter restarts from the beginning on every bounce.
- Reset release with a switch held high: sw_out stays 0, then rises with normal latency and emits a rise pulse. This is intended.
- Reset asserted mid-count: the count is discarded with no strobe. Debounce restarts from IDLE_LO after release.
- Simultaneous changes on several channels each resolve independently. Multiple strobe bits may be high in the same cycle.
- Counter never wraps: maximum value reached is DEBOUNCE_CYCLES-1.

Test Plan (S=2, N=4, 10 ns clk; E0 = first rising edge after sw_in change):
- Reset: hold rst_n=0 with sw_in=4'hF, clocking -> sw_out=0, rise=0, fall=0 throughout. Assert rst_n low between edges -> all outputs 0 immediately, before the next edge.
- Clean press: sw_in 0->4'b0001, then hold -> sw_out[0]=1 and rise=4'b0001 at E5 only. rise returns to 0 at E6. Other bits stay 0.
- Bounce rejection: sw_in[1] high for 3 cycles, low for 1, then high and held -> no change until 4 consecutive synchronised-high cycles. rise[1] pulses exactly once. A lone 3-cycle pulse gives no output change.
- Release: with sw_out=4'b0001, set sw_in=0 -> sw_out=0 and fall=4'b0001 for one cycle at E5. rise stays 0.
- Simultaneous channels: sw_in 0->4'hF in one step -> sw_out=4'hF and rise=4'hF in the same cycle (E5). Then 4'hF->4'hA -> fall=4'b0101 at E5, sw_out=4'hA.
- Mid-operation reset: pulse rst_n low at E3 of a pending press -> no rise pulse, sw_out=0. After release with the switch still high, sw_out rises at the normal latency and rise pulses once.

Source files
------------

// File: rtl/sw_debounce4_if.sv
// Switch conditioner bus: raw switch levels in, debounced levels and edge strobes out.
// The master side drives the raw switches; the slave side is the conditioner itself.
interface sw_debounce4_if;
    logic [3:0] sw_in;
    logic [3:0] sw_out;
    logic [3:0] rise;
    logic [3:0] fall;

    modport master (
        output sw_in,
        input  sw_out,
        input  rise,
        input  fall
    );

    modport slave (
        input  sw_in,
        output sw_out,
        output rise,
        output fall
    );
endinterface

// File: rtl/sw_debounce4.sv
// Four independent switch channels: multi-flop synchroniser, then a per-channel
// debounce FSM that accepts a new level only after it has held for DEBOUNCE_CYCLES clocks.
module sw_debounce4 #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    sw_debounce4_if.slave   sw
);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        IDLE_HI = 2'd2,
        CHK_LO  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [3:0] sync_reg [SYNC_STAGES];
    logic [3:0] sync_level;
    logic [3:0] sw_out_bits;
    logic [3:0] rise_bits;
    logic [3:0] fall_bits;

    // Plain flop chain; nothing may sit between stages or metastability settling time is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
        end else begin
            sync_reg[0] <= sw.sw_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    assign sync_level = sync_reg[SYNC_STAGES-1];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            state_t                 state_reg, state_next;
            logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;
            logic                   out_reg, out_next;
            logic                   rise_reg, rise_next;
            logic                   fall_reg, fall_next;
            logic                   level;

            assign level = sync_level[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= IDLE_LO;
                    cnt_reg   <= '0;
                    out_reg   <= 1'b0;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    out_reg   <= out_next;
                    rise_reg  <= rise_next;
                    fall_reg  <= fall_next;
                end
            end

            // A bounce back to the settled level drops the candidate and zeroes the count,
            // so a new attempt always needs the full DEBOUNCE_CYCLES of stability.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                out_next   = out_reg;
                rise_next  = 1'b0;
                fall_next  = 1'b0;
                case (state_reg)
                    IDLE_LO: begin
                        if (level) begin
                            state_next = CHK_HI;
                            cnt_next   = CNT_ONE;
                        end else begin
                            cnt_next   = '0;
                        end
                    end
                    CHK_HI: begin
                        if (!level) begin
                            state_next = IDLE_LO;
                            cnt_next   = '0;
                        end else if (cnt_reg == CNT_LAST) begin
                            state_next = IDLE_HI;
                            cnt_next   = '0;
                            out_next   = 1'b1;
                            rise_next  = 1'b1;
                        end else begin
                            cnt_next   = cnt_reg + CNT_ONE;
                        end
                    end
                    IDLE_HI: begin
                        if (!level) begin
                            state_next = CHK_LO;
                            cnt_next   = CNT_ONE;
                        end else begin
                            cnt_next   = '0;
                        end
                    end
                    CHK_LO: begin
                        if (level) begin
                            state_next = IDLE_HI;
                            cnt_next   = '0;
                        end else if (cnt_reg == CNT_LAST) begin
                            state_next = IDLE_LO;
                            cnt_next   = '0;
                            out_next   = 1'b0;
                            fall_next  = 1'b1;
                        end else begin
                            cnt_next   = cnt_reg + CNT_ONE;
                        end
                    end
                    default: begin
                        state_next = IDLE_LO;
                        cnt_next   = '0;
                        out_next   = 1'b0;
                    end
                endcase
            end

            assign sw_out_bits[gi] = out_reg;
            assign rise_bits[gi]   = rise_reg;
            assign fall_bits[gi]   = fall_reg;
        end
    endgenerate

    assign sw.sw_out = sw_out_bits;
    assign sw.rise   = rise_bits;
    assign sw.fall   = fall_bits;

endmodule

// File: tb/tb_sw_debounce4.sv
// Directed bench for sw_debounce4 (S=2, N=4): stimulus queues expected strobe events,
// a negedge monitor pops them when a strobe appears and tracks the settled sw_out level.
module tb_sw_debounce4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   passes = 0;

    typedef struct {
        int         cyc;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] sw;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] cur_sw = 4'h0;

    sw_debounce4_if bus ();

    sw_debounce4 #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_WIDTH       (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_exp(input int at, input logic [3:0] r, input logic [3:0] f, input logic [3:0] s);
        exp_t e;
        e.cyc  = at;
        e.rise = r;
        e.fall = f;
        e.sw   = s;
        sb_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s cyc=%0d got sw/rise/fall=%h required=%h", name, cyc, act, exp);
    endtask

    // Drive at a falling edge; the next rising edge is E0, so the change lands at cyc+6.
    task automatic drive(input logic [3:0] v);
        @(negedge clk);
        bus.sw_in = v;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            cur_sw = 4'h0;
        end else if ((bus.rise | bus.fall) != 4'h0) begin
            checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_strobe cyc=%0d got rise=%b fall=%b sw_out=%b required no strobe",
                         cyc, bus.rise, bus.fall, bus.sw_out);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (cyc == e.cyc && bus.rise === e.rise && bus.fall === e.fall && bus.sw_out === e.sw) begin
                    passes++;
                    $display("strobe ok cyc=%0d rise=%b fall=%b sw_out=%b", cyc, bus.rise, bus.fall, bus.sw_out);
                end else begin
                    $display("FAIL strobe got cyc=%0d rise=%b fall=%b sw_out=%b required cyc=%0d rise=%b fall=%b sw_out=%b",
                             cyc, bus.rise, bus.fall, bus.sw_out, e.cyc, e.rise, e.fall, e.sw);
                end
                cur_sw = e.sw;
            end
        end else begin
            checks++;
            if (bus.sw_out === cur_sw) passes++;
            else $display("FAIL steady_sw_out cyc=%0d got %b required %b", cyc, bus.sw_out, cur_sw);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        bus.sw_in = 4'hF;

        // Reset held with switches high: outputs must stay zero.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("reset_hold", {bus.sw_out, bus.rise, bus.fall}, 12'h000);
        end
        bus.sw_in = 4'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press on channel 0.
        drive(4'b0001);
        push_exp(cyc + 6, 4'b0001, 4'b0000, 4'b0001);
        repeat (7) @(negedge clk);
        chk("rise_one_cycle", {bus.sw_out, bus.rise, bus.fall}, {4'b0001, 4'h0, 4'h0});
        repeat (3) @(negedge clk);

        // Release of channel 0.
        drive(4'b0000);
        push_exp(cyc + 6, 4'b0000, 4'b0001, 4'b0000);
        repeat (10) @(negedge clk);

        // Channel 1: 3 high, 1 low, then held high.
        drive(4'b0010);
        repeat (3) @(negedge clk);
        bus.sw_in = 4'b0000;
        @(negedge clk);
        bus.sw_in = 4'b0010;
        push_exp(cyc + 6, 4'b0010, 4'b0000, 4'b0010);
        repeat (10) @(negedge clk);

        // Lone 3-cycle pulse on channel 2 must be ignored.
        drive(4'b0110);
        repeat (3) @(negedge clk);
        bus.sw_in = 4'b0010;
        repeat (10) @(negedge clk);
        chk("lone_pulse", {bus.sw_out, bus.rise, bus.fall}, {4'b0010, 4'h0, 4'h0});

        drive(4'b0000);
        push_exp(cyc + 6, 4'b0000, 4'b0010, 4'b0000);
        repeat (10) @(negedge clk);

        // All channels together, then a partial release.
        drive(4'hF);
        push_exp(cyc + 6, 4'hF, 4'h0, 4'hF);
        repeat (10) @(negedge clk);
        drive(4'hA);
        push_exp(cyc + 6, 4'h0, 4'b0101, 4'hA);
        repeat (10) @(negedge clk);

        // Asynchronous reset between edges clears outputs immediately.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {bus.sw_out, bus.rise, bus.fall}, 12'h000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(cyc + 6, 4'hA, 4'h0, 4'hA);
        repeat (10) @(negedge clk);

        drive(4'h0);
        push_exp(cyc + 6, 4'h0, 4'hA, 4'h0);
        repeat (10) @(negedge clk);

        // Reset at E3 of a pending press: count discarded, restart after release.
        drive(4'b0001);
        c = cyc;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(cyc + 6, 4'b0001, 4'h0, 4'b0001);
        repeat (10) @(negedge clk);
        chk("mid_reset_final", {bus.sw_out, bus.rise, bus.fall}, {4'b0001, 4'h0, 4'h0});

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() == 0) passes++;
        else $display("FAIL missing_strobes got %0d pending required 0 (first expected at cyc=%0d, press at %0d)",
                      sb_q.size(), sb_q[0].cyc, c);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
